// File: rtl/trusted_evt_pkg.sv
// Shared types and helpers for the K-of-N trusted event detector.
// Combinational only; no latency, no backpressure.
package trusted_evt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        ACTIVE  = 2'd2
    } state_e;

    localparam int DROP_W    = 8;
    localparam int POP_MAX_W = 32;

    // Callers zero-extend their vector to POP_MAX_W and truncate the result to their own width.
    function automatic logic [5:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sensor_fault_tracker.sv
// Per-sensor disagreement counter: masks a sensor after FAULT_LIMIT consecutive disagreements.
// One cycle from the deciding disagreement to faulty_o; no backpressure.
module sensor_fault_tracker
    import trusted_evt_pkg::*;
#(
    parameter int FAULT_LIMIT = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   s_i,
    input  state_e state_i,
    input  logic   mask_clr_i,
    output logic   faulty_o
);

    localparam int             FW  = $clog2(FAULT_LIMIT + 1);
    localparam logic [FW-1:0]  LIM = FW'(FAULT_LIMIT);

    logic [FW-1:0] ctr_q, ctr_d;
    logic          faulty_q, faulty_d;
    logic          judged;
    logic          disagree;

    // CONFIRM is a transient; judging sensors there would punish early agreement.
    assign judged   = (state_i == IDLE) || (state_i == ACTIVE);
    assign disagree = ((state_i == IDLE) && s_i) || ((state_i == ACTIVE) && !s_i);

    always_comb begin
        ctr_d    = ctr_q;
        faulty_d = faulty_q;
        if (mask_clr_i) begin
            ctr_d    = '0;
            faulty_d = 1'b0;
        end else if (!faulty_q && judged) begin
            if (disagree) begin
                ctr_d = ctr_q + FW'(1);
                if (ctr_d == LIM) begin
                    faulty_d = 1'b1;
                end
            end else begin
                ctr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q    <= '0;
            faulty_q <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            faulty_q <= faulty_d;
        end
    end

    assign faulty_o = faulty_q;

endmodule

// File: rtl/trusted_event_detector.sv
// K-of-N voting event detector with persistence filter, faulty-sensor masking and a one-deep event record.
// Event at edge t+1+PERSIST for input stable from t; a still-pending record causes new events to be counted as drops.
module trusted_event_detector
    import trusted_evt_pkg::*;
#(
    parameter int N_SENSORS   = 3,
    parameter int K_THRESH    = 2,
    parameter int PERSIST     = 4,
    parameter int FAULT_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] sensor_in,
    input  logic                 mask_clr,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [N_SENSORS-1:0] evt_flag,
    output logic                 alarm,
    output logic [N_SENSORS-1:0] fault_mask,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int            VW  = $clog2(N_SENSORS + 1);
    localparam int            CW  = $clog2(PERSIST + 1);
    localparam logic [VW-1:0] K_V = VW'(K_THRESH);
    localparam logic [CW-1:0] P_V = CW'(PERSIST);

    logic [N_SENSORS-1:0] s_q;
    logic [N_SENSORS-1:0] live;
    logic [VW-1:0]        votes, act, thr;
    logic                 hit;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 evt_valid_q, evt_valid_d;
    logic [N_SENSORS-1:0] evt_flag_q, evt_flag_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic                 enter_active;
    logic                 handshake;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= sensor_in;
        end
    end

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_trk
        sensor_fault_tracker #(
            .FAULT_LIMIT(FAULT_LIMIT)
        ) u_trk (
            .clk       (clk),
            .rst       (rst),
            .s_i       (s_q[i]),
            .state_i   (state_q),
            .mask_clr_i(mask_clr),
            .faulty_o  (fault_mask[i])
        );
    end

    // Threshold shrinks with the number of trusted sensors so masking never makes an event impossible.
    assign live  = ~fault_mask;
    assign votes = VW'(popcount(POP_MAX_W'(s_q & live)));
    assign act   = VW'(popcount(POP_MAX_W'(live)));
    assign thr   = (K_V < act) ? K_V : act;
    assign hit   = (act != '0) && (votes >= thr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (PERSIST == 1) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = CW'(1);
                    end
                end
            end
            CONFIRM: begin
                if (!hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == P_V) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end
                end
            end
            ACTIVE: begin
                if (!hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign enter_active = (state_d == ACTIVE) && (state_q != ACTIVE);
    assign handshake    = evt_valid_q && evt_ready;

    // A record being accepted on the entry edge frees the slot for the new one.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_flag_d  = evt_flag_q;
        drop_d      = drop_q;
        if (handshake) begin
            evt_valid_d = 1'b0;
        end
        if (enter_active) begin
            if (!evt_valid_q || handshake) begin
                evt_valid_d = 1'b1;
                evt_flag_d  = s_q & live;
            end else if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_flag_q  <= '0;
            drop_q      <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_flag_q  <= evt_flag_d;
            drop_q      <= drop_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_flag  = evt_flag_q;
    assign drop_cnt  = drop_q;
    assign alarm     = (state_q == ACTIVE);

endmodule

// File: tb/tb_trusted_event_detector.sv
// Scenario bench for trusted_event_detector (N=3, K=2, PERSIST=4, FAULT_LIMIT=3).
// Expected event records are queued at stimulus time and checked on each accepted handshake.
module tb_trusted_event_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sensor_in;
    logic       mask_clr;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_flag;
    logic       alarm;
    logic [2:0] fault_mask;
    logic [7:0] drop_cnt;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] sb[$];
    logic [2:0] exp_flag;

    trusted_event_detector #(
        .N_SENSORS  (3),
        .K_THRESH   (2),
        .PERSIST    (4),
        .FAULT_LIMIT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_in (sensor_in),
        .mask_clr  (mask_clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_flag  (evt_flag),
        .alarm     (alarm),
        .fault_mask(fault_mask),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Inputs are stable by the falling edge, so a valid&&ready seen here is accepted at the next rising edge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL record_unexpected: got flag %b, expected no record", evt_flag);
            end else begin
                exp_flag = sb.pop_front();
                if (evt_flag !== exp_flag) begin
                    errors++;
                    $display("FAIL record_flag: got %b expected %b", evt_flag, exp_flag);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sensor_in = 3'b000; mask_clr = 1'b0; evt_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
        checks++; if (evt_flag !== 3'b000) begin errors++; $display("FAIL reset_flag: got %b expected 000", evt_flag); end
        checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL reset_mask: got %b expected 000", fault_mask); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        #19 rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic_event();
        sensor_in = 3'b111; sb.push_back(3'b111);
        cyc(4);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early: got %b expected 0", evt_valid); end
        cyc(1);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_edge5: got %b expected 1", evt_valid); end
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL t1_alarm_edge5: got %b expected 1", alarm); end
        checks++; if (evt_flag !== 3'b111) begin errors++; $display("FAIL t1_flag: got %b expected 111", evt_flag); end
        cyc(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_pulse: got %b expected 0", evt_valid); end
        cyc(2);
        sensor_in = 3'b000;
        cyc(1);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL t1_alarm_hold: got %b expected 1", alarm); end
        cyc(1);
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL t1_alarm_drop: got %b expected 0", alarm); end
        cyc(3);
    endtask

    task automatic test_fault_mask();
        sensor_in = 3'b010;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            checks++; if (evt_valid !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL t2_no_event: cycle %0d got valid=%b alarm=%b expected 0 0", i, evt_valid, alarm); end
            if (i == 3) begin
                checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL t2_mask_early: got %b expected 000", fault_mask); end
            end
            if (i == 4) begin
                checks++; if (fault_mask !== 3'b010) begin errors++; $display("FAIL t2_mask_edge4: got %b expected 010", fault_mask); end
            end
        end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL t2_drop: got %0d expected 0", drop_cnt); end
        sensor_in = 3'b000; mask_clr = 1'b1;
        cyc(1);
        mask_clr = 1'b0;
        checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL t2_mask_clr: got %b expected 000", fault_mask); end
        cyc(3);
    endtask

    task automatic test_abort_confirm();
        sensor_in = 3'b110;
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            if (i == 3) sensor_in = 3'b000;
            checks++; if (evt_valid !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL t3_no_event: cycle %0d got valid=%b alarm=%b expected 0 0", i, evt_valid, alarm); end
        end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        sensor_in = 3'b111; sb.push_back(3'b111);
        cyc(5);
        checks++; if (evt_valid !== 1'b1 || evt_flag !== 3'b111) begin errors++; $display("FAIL t4_first: got valid=%b flag=%b expected 1 111", evt_valid, evt_flag); end
        cyc(1);
        sensor_in = 3'b000;
        cyc(6);
        checks++; if (evt_valid !== 1'b1 || alarm !== 1'b0) begin errors++; $display("FAIL t4_pending_idle: got valid=%b alarm=%b expected 1 0", evt_valid, alarm); end
        sensor_in = 3'b110;
        cyc(5);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL t4_second_alarm: got %b expected 1", alarm); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL t4_drop: got %0d expected 1", drop_cnt); end
        checks++; if (evt_flag !== 3'b111) begin errors++; $display("FAIL t4_payload_hold: got %b expected 111", evt_flag); end
        sensor_in = 3'b000;
        cyc(4);
        evt_ready = 1'b1;
        cyc(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL t4_valid_fall: got %b expected 0", evt_valid); end
        cyc(2);
    endtask

    task automatic test_masked_threshold();
        sensor_in = 3'b100;
        cyc(4);
        checks++; if (fault_mask !== 3'b100) begin errors++; $display("FAIL t5_mask_temp: got %b expected 100", fault_mask); end
        sensor_in = 3'b010;
        cyc(4);
        checks++; if (fault_mask !== 3'b110) begin errors++; $display("FAIL t5_mask_smoke: got %b expected 110", fault_mask); end
        sensor_in = 3'b001; sb.push_back(3'b001);
        cyc(4);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL t5_valid_early: got %b expected 0", evt_valid); end
        cyc(1);
        checks++; if (evt_valid !== 1'b1 || evt_flag !== 3'b001) begin errors++; $display("FAIL t5_event: got valid=%b flag=%b expected 1 001", evt_valid, evt_flag); end
        sensor_in = 3'b000;
        cyc(3);
        mask_clr = 1'b1;
        cyc(1);
        mask_clr = 1'b0;
        checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL t5_mask_clr: got %b expected 000", fault_mask); end
        cyc(2);
    endtask

    task automatic test_reset_mid_confirm();
        sensor_in = 3'b111;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        checks++; if (evt_valid !== 1'b0 || alarm !== 1'b0 || evt_flag !== 3'b000) begin errors++; $display("FAIL t6_async_evt: got valid=%b alarm=%b flag=%b expected 0 0 000", evt_valid, alarm, evt_flag); end
        checks++; if (drop_cnt !== 8'd0 || fault_mask !== 3'b000) begin errors++; $display("FAIL t6_async_stat: got drop=%0d mask=%b expected 0 000", drop_cnt, fault_mask); end
        #3 rst = 1'b0;
        sb.push_back(3'b111);
        cyc(4);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL t6_restart_early: got %b expected 0", evt_valid); end
        cyc(1);
        checks++; if (evt_valid !== 1'b1 || evt_flag !== 3'b111) begin errors++; $display("FAIL t6_restart_event: got valid=%b flag=%b expected 1 111", evt_valid, evt_flag); end
        sensor_in = 3'b000;
        cyc(4);
    endtask

    initial begin
        test_reset();
        test_basic_event();
        test_fault_mask();
        test_abort_confirm();
        test_back_to_back();
        test_masked_threshold();
        test_reset_mid_confirm();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL records_outstanding: got %0d undelivered expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
